// File: rtl/id_decode_stage_if.sv
// id_decode_stage_if: fetch handshake, register-file read port and execute-side bundle of the decode stage.
interface id_decode_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic        flush;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_opcode;
  logic [2:0]  out_func3;
  logic        out_func7;
  logic [63:0] out_op1;
  logic [63:0] out_op2;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic [63:0] out_store_data;
  logic [63:0] out_target;
  logic        out_illegal;
  modport master (
    output in_valid, in_instr, in_pc, flush, rs1_data, rs2_data, out_ready,
    input  in_ready, rs1_addr, rs2_addr, out_valid, out_opcode, out_func3, out_func7,
           out_op1, out_op2, out_rd, out_rd_we, out_store_data, out_target, out_illegal
  );
  modport slave (
    input  in_valid, in_instr, in_pc, flush, rs1_data, rs2_data, out_ready,
    output in_ready, rs1_addr, rs2_addr, out_valid, out_opcode, out_func3, out_func7,
           out_op1, out_op2, out_rd, out_rd_we, out_store_data, out_target, out_illegal
  );
endinterface

// File: rtl/id_decode_stage.sv
// id_decode_stage: RV64I decode stage with a one-entry output register; DECODE_ILLEGAL_CHECK_EN adds illegal-instruction detection.
module id_decode_stage (
  input logic clk,
  input logic rst_n,
  id_decode_stage_if.slave bus
);
  logic [31:2] i;
  logic [4:0]  opc;
  logic [2:0]  f3;
  logic [63:0] rs1, rs2, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [63:0] op1, op2, tgt, sd;
  logic        f7, known, ill, we, acc;
  assign i = bus.in_instr[31:2];
  assign opc = i[6:2];
  assign f3 = i[14:12];
  assign bus.rs1_addr = i[19:15];
  assign bus.rs2_addr = i[24:20];
  assign rs1 = i[19:15] == 5'd0 ? 64'd0 : bus.rs1_data;
  assign rs2 = i[24:20] == 5'd0 ? 64'd0 : bus.rs2_data;
  assign imm_i = {{52{i[31]}}, i[31:20]};
  assign imm_s = {{52{i[31]}}, i[31:25], i[11:7]};
  assign imm_b = {{52{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
  assign imm_u = {{32{i[31]}}, i[31:12], 12'd0};
  assign imm_j = {{44{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign acc = bus.in_valid && bus.in_ready && !bus.flush;
  always_comb begin
    op1 = '0;
    op2 = '0;
    tgt = '0;
    sd = '0;
    f7 = 1'b0;
    known = 1'b1;
    case (opc)
      5'b01100, 5'b01110: begin op1 = rs1; op2 = rs2; f7 = i[30]; end
      5'b00100, 5'b00110: begin op1 = rs1; op2 = imm_i; f7 = f3 == 3'b101 && i[30]; end
      5'b01101: op2 = imm_u;
      5'b00101: begin op1 = bus.in_pc; op2 = imm_u; end
      5'b11011: begin op1 = bus.in_pc; tgt = bus.in_pc + imm_j; end
      5'b11001: begin op1 = bus.in_pc; tgt = (rs1 + imm_i) & ~64'd1; end
      5'b11000: begin op1 = rs1; op2 = rs2; tgt = bus.in_pc + imm_b; end
      5'b00000: begin op1 = rs1; op2 = imm_i; end
      5'b01000: begin op1 = rs1; op2 = imm_s; sd = rs2; end
      default: known = 1'b0;
    endcase
  end
`ifdef DECODE_ILLEGAL_CHECK_EN
  logic r_type, w_type, bad_r;
  assign r_type = opc == 5'b01100 || opc == 5'b01110;
  assign w_type = opc == 5'b00110 || opc == 5'b01110;
  assign bad_r = r_type && (i[31:25] == 7'h20 ? !(f3 inside {3'b000, 3'b101}) : i[31:25] != 7'h00);
  assign ill = bus.in_instr[1:0] != 2'b11 || !known || bad_r ||
               (w_type && !(f3 inside {3'b000, 3'b001, 3'b101})) ||
               (opc == 5'b11001 && f3 != 3'b000) || (opc == 5'b11000 && f3[2:1] == 2'b01) ||
               (opc == 5'b00000 && f3 == 3'b111) || (opc == 5'b01000 && f3[2]);
`else
  assign ill = 1'b0;
`endif
  // branches and stores never write rd; x0 is never written
  assign we = known && !ill && opc != 5'b11000 && opc != 5'b01000 && i[11:7] != 5'd0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_opcode <= '0;
      bus.out_func3 <= '0;
      bus.out_func7 <= 1'b0;
      bus.out_op1 <= '0;
      bus.out_op2 <= '0;
      bus.out_rd <= '0;
      bus.out_rd_we <= 1'b0;
      bus.out_store_data <= '0;
      bus.out_target <= '0;
      bus.out_illegal <= 1'b0;
    end else begin
      bus.out_valid <= !bus.flush && (acc || (bus.out_valid && !bus.out_ready));
      if (acc) begin
        bus.out_opcode <= opc;
        bus.out_func3 <= f3;
        bus.out_func7 <= f7;
        bus.out_op1 <= ill ? 64'd0 : op1;
        bus.out_op2 <= ill ? 64'd0 : op2;
        bus.out_rd <= i[11:7];
        bus.out_rd_we <= we;
        bus.out_store_data <= ill ? 64'd0 : sd;
        bus.out_target <= ill ? 64'd0 : tgt;
        bus.out_illegal <= ill;
      end
    end
endmodule
